// File: rtl/logic_arb_pkg.sv
// Shared constants and types for the two-port logic-unit arbiter.
package logic_arb_pkg;

    localparam int DATA_W = 64;

    localparam logic [1:0] LOGIC_NOT = 2'b00;
    localparam logic [1:0] LOGIC_AND = 2'b01;
    localparam logic [1:0] LOGIC_OR  = 2'b10;
    localparam logic [1:0] LOGIC_XOR = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/logic_arbiter_unit.sv
// Combinational 64-bit bitwise logic unit: NOT, AND, OR, XOR.
module logic_arbiter_unit
    import logic_arb_pkg::*;
(
    input  logic [1:0]        i_ctrl,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            LOGIC_NOT: o_result = ~i_op1;
            LOGIC_AND: o_result = i_op1 & i_op2;
            LOGIC_OR:  o_result = i_op1 | i_op2;
            LOGIC_XOR: o_result = i_op1 ^ i_op2;
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter with burst lock in front of the shared logic unit,
// followed by a single registered result stage with backpressure.
//
// state    | meaning
// ARB_IDLE | no lock; grant by valid, ties broken by r_prio
// ARB_OWN0 | requester 0 holds the unit until it sends a last beat
// ARB_OWN1 | requester 1 holds the unit until it sends a last beat
module logic_arbiter
    import logic_arb_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_ctrl,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req0_last,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_ctrl,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [TAG_W-1:0]  req1_tag,
    input  logic              req1_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_src,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_last,
    output logic              busy
);

    arb_state_t        r_state;
    logic              r_prio;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_src;
    logic [TAG_W-1:0]  r_res_tag;
    logic              r_res_last;

    logic              w_can_accept;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc;
    logic              w_acc_last;
    logic [TAG_W-1:0]  w_acc_tag;
    logic [1:0]        w_ctrl;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic [DATA_W-1:0] w_result;

    assign w_can_accept = ~r_res_valid | res_ready;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_gnt0 = req0_valid & (~req1_valid | ~r_prio);
                w_gnt1 = req1_valid & (~req0_valid |  r_prio);
            end
            ARB_OWN0: w_gnt0 = 1'b1;
            ARB_OWN1: w_gnt1 = 1'b1;
            default:  ;
        endcase
    end

    assign req0_ready = w_gnt0 & w_can_accept;
    assign req1_ready = w_gnt1 & w_can_accept;

    // Grants are mutually exclusive, so w_gnt1 alone selects the source.
    assign w_acc      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_ctrl     = w_gnt1 ? req1_ctrl : req0_ctrl;
    assign w_op1      = w_gnt1 ? req1_op1  : req0_op1;
    assign w_op2      = w_gnt1 ? req1_op2  : req0_op2;
    assign w_acc_tag  = w_gnt1 ? req1_tag  : req0_tag;
    assign w_acc_last = w_gnt1 ? req1_last : req0_last;

    logic_arbiter_unit u_unit (
        .i_ctrl   (w_ctrl),
        .i_op1    (w_op1),
        .i_op2    (w_op2),
        .o_result (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_prio      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_src   <= 1'b0;
            r_res_tag   <= '0;
            r_res_last  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_res_valid <= 1'b1;
                r_res_data  <= w_result;
                r_res_src   <= w_gnt1;
                r_res_tag   <= w_acc_tag;
                r_res_last  <= w_acc_last;
                case (r_state)
                    ARB_IDLE: begin
                        if (!w_acc_last)
                            r_state <= w_gnt1 ? ARB_OWN1 : ARB_OWN0;
                        else
                            r_prio <= ~w_gnt1;
                    end
                    ARB_OWN0, ARB_OWN1: begin
                        if (w_acc_last) begin
                            r_state <= ARB_IDLE;
                            r_prio  <= ~w_gnt1;
                        end
                    end
                    default: r_state <= ARB_IDLE;
                endcase
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_src   = r_res_src;
    assign res_tag   = r_res_tag;
    assign res_last  = r_res_last;
    assign busy      = (r_state != ARB_IDLE) | r_res_valid;

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter: a cycle model checked at every falling
// edge plus literal expectations for each scenario.
module tb_logic_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_ctrl,  req1_ctrl;
    logic [63:0] req0_op1,   req1_op1;
    logic [63:0] req0_op2,   req1_op2;
    logic [3:0]  req0_tag,   req1_tag;
    logic        req0_last,  req1_last;
    logic        res_valid,  res_ready;
    logic [63:0] res_data;
    logic        res_src;
    logic [3:0]  res_tag;
    logic        res_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic_arbiter #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req0_tag   (req0_tag),
        .req0_last  (req0_last),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .req1_tag   (req1_tag),
        .req1_last  (req1_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_src    (res_src),
        .res_tag    (res_tag),
        .res_last   (res_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] op_ref(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b);
        case (c)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Model: owner is -1 when unlocked; rr is the requester favoured on a tie.
    int          m_owner = -1;
    int          m_rr    = 0;
    bit          m_valid = 0;
    logic [63:0] m_data  = '0;
    int          m_src   = 0;
    logic [3:0]  m_tag   = '0;
    bit          m_last  = 0;

    always @(negedge clk) begin
        bit can, g0, g1, r0, r1;
        int acc;
        if (!rst_n) begin
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            m_owner = -1; m_rr = 0; m_valid = 0;
        end else begin
            can = !m_valid || res_ready;
            if (m_owner == 0)      begin g0 = 1; g1 = 0; end
            else if (m_owner == 1) begin g0 = 0; g1 = 1; end
            else if (req0_valid && req1_valid) begin g0 = (m_rr == 0); g1 = (m_rr == 1); end
            else begin g0 = req0_valid; g1 = req1_valid; end
            r0 = g0 && can;
            r1 = g1 && can;
            chk("mdl_req0_ready", req0_ready, r0);
            chk("mdl_req1_ready", req1_ready, r1);
            chk("mdl_res_valid", res_valid, m_valid);
            chk("mdl_busy", busy, (m_owner != -1) || m_valid);
            if (m_valid) begin
                chk("mdl_res_data", res_data, m_data);
                chk("mdl_res_src", res_src, m_src);
                chk("mdl_res_tag", res_tag, m_tag);
                chk("mdl_res_last", res_last, m_last);
            end
            acc = (req0_valid && r0) ? 0 : ((req1_valid && r1) ? 1 : -1);
            if (acc == 0) begin
                m_data = op_ref(req0_ctrl, req0_op1, req0_op2);
                m_tag = req0_tag; m_last = req0_last;
            end else if (acc == 1) begin
                m_data = op_ref(req1_ctrl, req1_op1, req1_op2);
                m_tag = req1_tag; m_last = req1_last;
            end
            if (acc >= 0) begin
                m_valid = 1;
                m_src = acc;
                if (m_last) begin
                    m_owner = -1;
                    m_rr = 1 - acc;
                end else begin
                    m_owner = acc;
                end
            end else if (res_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; res_ready = 0;
        req0_valid = 0; req0_ctrl = 0; req0_op1 = 0; req0_op2 = 0; req0_tag = 0; req0_last = 1;
        req1_valid = 0; req1_ctrl = 0; req1_op1 = 0; req1_op2 = 0; req1_tag = 0; req1_last = 1;
        repeat (3) step();
        chk("reset_res_valid", res_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready0", req0_ready, 0);
        chk("reset_ready1", req1_ready, 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_res_src", res_src, 0);
        chk("reset_res_tag", res_tag, 0);
        chk("reset_res_last", res_last, 0);
        rst_n = 1;

        // Single AND from requester 0
        step();
        res_ready = 1;
        req0_valid = 1; req0_ctrl = 2'b01; req0_op1 = 64'hFF00FF00FF00FF00;
        req0_op2 = 64'h0F0F0F0F0F0F0F0F; req0_tag = 4'h2; req0_last = 1;
        #1 chk("and_ready0", req0_ready, 1);
        step();
        req0_valid = 0;
        chk("and_valid", res_valid, 1);
        chk("and_data", res_data, 64'h0F000F000F000F00);
        chk("and_src", res_src, 0);
        chk("and_last", res_last, 1);

        // NOT from requester 1 ignores op2
        req1_valid = 1; req1_ctrl = 2'b00; req1_op1 = 64'h0; req1_op2 = 64'hDEAD;
        req1_tag = 4'h5; req1_last = 1;
        #1 chk("not_ready1", req1_ready, 1);
        step();
        req1_valid = 0;
        chk("not_data", res_data, 64'hFFFFFFFFFFFFFFFF);
        chk("not_tag", res_tag, 4'h5);
        chk("not_src", res_src, 1);

        // Round robin with both requesters streaming single beats
        req0_valid = 1; req0_ctrl = 2'b10; req0_op1 = 64'h1; req0_op2 = 64'h2; req0_tag = 4'h1; req0_last = 1;
        req1_valid = 1; req1_ctrl = 2'b11; req1_op1 = 64'h3; req1_op2 = 64'h5; req1_tag = 4'h7; req1_last = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_valid", res_valid, 1);
            chk("rr_src", res_src, k % 2);
        end
        chk("rr_data_last", res_data, 64'h6);

        // Burst lock: requester 0 sends three beats while requester 1 waits
        req0_last = 0; req0_ctrl = 2'b01; req0_op1 = 64'hF0; req0_op2 = 64'h3C;
        for (int k = 0; k < 3; k++) begin
            req0_last = (k == 2);
            req0_tag = 4'(8 + k);
            #1 chk("burst_ready1", req1_ready, 0);
            step();
            chk("burst_src", res_src, 0);
            chk("burst_tag", res_tag, 8 + k);
        end
        chk("burst_data", res_data, 64'h30);
        req0_last = 1;
        req1_ctrl = 2'b11; req1_op1 = 64'hAAAAAAAAAAAAAAAA; req1_op2 = 64'hFFFFFFFFFFFFFFFF;
        req1_tag = 4'h3; req1_last = 1;
        #1 chk("after_burst_ready1", req1_ready, 1);
        chk("after_burst_ready0", req0_ready, 0);

        // Backpressure: hold the requester 1 result for four cycles
        step();
        req1_valid = 0;
        res_ready = 0;
        req0_ctrl = 2'b10; req0_op1 = 64'h00F0; req0_op2 = 64'h0F00; req0_tag = 4'h9; req0_last = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 64'h5555555555555555);
            chk("bp_src", res_src, 1);
            chk("bp_tag", res_tag, 4'h3);
            step();
        end
        res_ready = 1;
        #1 chk("bp_release_ready0", req0_ready, 1);
        step();
        req0_valid = 0;
        chk("bp_new_data", res_data, 64'h0FF0);
        chk("bp_new_src", res_src, 0);
        chk("bp_new_tag", res_tag, 4'h9);

        // Reset while requester 1 holds the lock and a result is pending
        req1_valid = 1; req1_ctrl = 2'b01; req1_last = 0; req1_tag = 4'hC;
        step();
        res_ready = 0;
        req1_valid = 0;
        chk("lock_valid", res_valid, 1);
        chk("lock_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready0", req0_ready, 0);
        chk("midrst_ready1", req1_ready, 0);
        req0_valid = 1; req0_last = 1;
        req1_valid = 1; req1_last = 1;
        step();
        rst_n = 1;
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        step();
        req0_valid = 0; req1_valid = 0;
        chk("post_rst_src", res_src, 0);
        chk("post_rst_valid", res_valid, 1);
        res_ready = 1;
        step();
        chk("drain_busy", busy, 0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_arbiter.md
# logic_arbiter

Two-port arbiter and sequencer for the shared 64-bit bitwise logic unit (NOT/AND/OR/XOR). Requester 0 and requester 1, for example the integer issue pipe and a secondary or debug issue path, present operations over valid/ready handshakes. The block grants one requester per cycle using round-robin priority and can lock the grant for multi-beat bursts. It registers each result in a single output stage with backpressure.

## Interface
- TAG_W, 4, width of the opaque tag carried from request to result
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  request N (N = 0, 1) presents a beat
- reqN_ready  out  1  beat from requester N is accepted this cycle
- reqN_ctrl  in  2  operation: 00 NOT op1, 01 AND, 10 OR, 11 XOR
- reqN_op1  in  64  first operand
- reqN_op2  in  64  second operand; ignored for NOT
- reqN_tag  in  TAG_W  tag, returned unchanged with the result
- reqN_last  in  1  final beat of a burst; 1 for single operations
- res_valid  out  1  result register holds a valid beat
- res_ready  in  1  consumer takes the result this cycle
- res_data  out  64  operation result
- res_src  out  1  index of the requester that issued the beat
- res_tag  out  TAG_W  tag of the issuing beat
- res_last  out  1  copy of the issuing beat's last flag
- busy  out  1  high when state != ARB_IDLE or res_valid = 1

## Operation
- State is ARB_IDLE, ARB_OWN0 or ARB_OWN1. The block also holds a 1-bit round-robin pointer `prio`.
- can_accept = !res_valid | res_ready.
- Grant in ARB_IDLE:
  - If exactly one requester is valid, it is granted.
  - If both are valid, requester `prio` is granted.
  - reqN_ready may depend on reqN_valid. Requesters must not make valid depend on ready.
- Grant in ARB_OWNi: only requester i is granted. The other requester's ready is 0 regardless of its valid.
- reqN_ready = granted_N & can_accept. A beat is accepted when reqN_valid and reqN_ready are both high.
- On accepting a beat from requester i:
  - res_data <= op(ctrl, op1, op2).
  - res_src <= i. res_tag and res_last are copied from the beat.
  - res_valid <= 1.
- If no beat is accepted and res_ready = 1, res_valid <= 0.
- Transitions on acceptance:
  - ARB_IDLE with last = 0 -> ARB_OWNi.
  - ARB_IDLE with last = 1 -> stay in ARB_IDLE, prio <= ~i.
  - ARB_OWNi with last = 1 -> ARB_IDLE, prio <= ~i.
  - ARB_OWNi with last = 0 -> stay in ARB_OWNi.
- In ARB_OWNi, a gap in reqi_valid does not release the lock; the state holds until a last beat is accepted.
- All result arithmetic is pure 64-bit bitwise, with no carry, flags or sign handling.
- Reset values:
  - res_valid = 0; res_data, res_src, res_tag and res_last = 0.
  - state = ARB_IDLE, prio = 0.
  - Therefore busy = 0 and both readies = 0.
- Reset asserted mid-burst or with a result pending discards both the lock and the pending result. There is no replay.

## Timing
- Latency: a beat accepted in cycle t appears on res_* in cycle t+1.
- Throughput: 1 beat per cycle while res_ready is held high.
- While res_valid = 1 and res_ready = 0, all res_* outputs are held stable and both readies are 0.
- A result consumed in the same cycle as a new acceptance is replaced with no bubble.
- There is no combinational path from reqN_op*, reqN_ctrl or reqN_tag to any output.
- Combinational paths res_ready -> reqN_ready and reqN_valid -> reqM_ready (ARB_IDLE only) are permitted.

## Structure
- Package `logic_arb_pkg` holds:
  - DATA_W = 64.
  - Op localparams LOGIC_NOT = 2'b00, LOGIC_AND = 2'b01, LOGIC_OR = 2'b10, LOGIC_XOR = 2'b11.
  - Typedef `arb_state_t` {ARB_IDLE, ARB_OWN0, ARB_OWN1}.
- One sub-module: the existing combinational `logic` unit, instantiated once. It is fed by the grant-selected ctrl/op1/op2 mux, and its output drives the result register.

## Test plan
- Single AND: after reset, req0 sends ctrl = 01, op1 = 0xFF00FF00FF00FF00, op2 = 0x0F0F0F0F0F0F0F0F, last = 1, with res_ready = 1. Required: next cycle res_valid = 1, res_data = 0x0F000F000F000F00, res_src = 0, res_last = 1.
- NOT ignores op2: req1 sends ctrl = 00, op1 = 0, op2 = 0xDEAD, tag = 0x5. Required: res_data = 0xFFFFFFFFFFFFFFFF, res_tag = 0x5, res_src = 1.
- Round robin: both requesters continuously send single beats (last = 1). Required: res_src sequence 0, 1, 0, 1 with one result per cycle.
- Burst lock: req0 sends 3 beats with last on the third while req1 is valid throughout. Required: req1_ready = 0 for 3 cycles, res_src = 0, 0, 0, then req1 is granted on the next cycle.
- Backpressure: with res_valid = 1, hold res_ready = 0 for 4 cycles. Required: res_* stable and both readies 0. When res_ready rises, a pending beat is accepted in that same cycle and the new result appears on the next cycle.
- Reset mid-burst: assert rst_n = 0 while in ARB_OWN1 with res_valid = 1. Required: res_valid = 0 and busy = 0 immediately. After release, with both requesters valid, req0 is granted first.
